// File: rtl/gpu_pkg.sv
// gpu_pkg: shared constants for the GPU host register bank.
// Register addresses, CMD opcodes, STATUS bit positions and the engine
// state encoding used by gpu_regs and gpu_rect_walker.
package gpu_pkg;

  localparam logic [7:0] A_X0     = 8'h00;
  localparam logic [7:0] A_Y0     = 8'h01;
  localparam logic [7:0] A_X1     = 8'h02;
  localparam logic [7:0] A_Y1     = 8'h03;
  localparam logic [7:0] A_COLOR  = 8'h04;
  localparam logic [7:0] A_CMD    = 8'h05;
  localparam logic [7:0] A_STATUS = 8'h06;
  localparam logic [7:0] A_DATA   = 8'h07;

  localparam logic [7:0] CMD_FILL  = 8'h01;
  localparam logic [7:0] CMD_XFILL = 8'h03;

  localparam int ST_BUSY = 0;
  localparam int ST_ERR  = 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FILL     = 3'd1,
    S_DPORT_WR = 3'd2,
    S_PF_RD    = 3'd3,
    S_PF_WAIT  = 3'd4,
    S_XR       = 3'd5,
    S_XW       = 3'd6,
    S_XWR      = 3'd7
  } state_t;

endpackage

// File: rtl/gpu_rect_walker.sv
// gpu_rect_walker: raster scan counter for rectangle operations.
// Latches the rectangle bounds on start so later register activity cannot
// disturb a running operation; steps left-to-right, then top-to-bottom.
module gpu_rect_walker
  import gpu_pkg::*;
#(
  parameter int COORD_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               step,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  output logic [COORD_W-1:0] cx,
  output logic [COORD_W-1:0] cy,
  output logic               last
);

  logic [COORD_W-1:0] lx0, lx1, ly1;

  // Bound capture on start, raster advance on each accepted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lx0 <= '0;
      lx1 <= '0;
      ly1 <= '0;
      cx  <= '0;
      cy  <= '0;
    end else if (start) begin
      lx0 <= x0;
      lx1 <= x1;
      ly1 <= y1;
      cx  <= x0;
      cy  <= y0;
    end else if (step) begin
      if (cx == lx1) begin
        cx <= lx0;
        cy <= cy + 1'b1;
      end else begin
        cx <= cx + 1'b1;
      end
    end
  end

  assign last = (cx == lx1) && (cy == ly1);

endmodule

// File: rtl/gpu_regs.sv
// gpu_regs: host register bank, cursor data port and rectangle engine.
// Optional feature macro: GPU_XOR_EN enables CMD 0x03 (XOR-FILL, a
// read-modify-write per pixel); without it 0x03 is rejected as invalid.
module gpu_regs
  import gpu_pkg::*;
#(
  parameter int COORD_W = 8,
  parameter int FB_AW   = 2 * COORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       ip_addr,
  input  logic [7:0]       ip_do,
  input  logic             ip_wr,
  input  logic             ip_rd,
  output logic [7:0]       ip_di,
  output logic [FB_AW-1:0] fb_addr,
  output logic [7:0]       fb_wdata,
  output logic             fb_we,
  output logic             fb_re,
  input  logic             fb_ready,
  input  logic [7:0]       fb_rdata,
  output logic             busy
);

  state_t state, state_nx;

  logic [COORD_W-1:0] x0, y0, x1, y1;
  logic [7:0]         color;
  logic               err;
  logic [7:0]         pf;
  logic               pf_stale;
  logic [FB_AW-1:0]   pf_addr;
  logic [FB_AW-1:0]   dp_addr;
  logic [7:0]         dp_data;

  logic [COORD_W-1:0] cx, cy;
  logic               w_start, w_step, w_last;
  logic               pf_go, pf_load;

  logic idle, wr_status, wr_reg, wr_ok, wr_drop;
  logic cmd_wr, rect_bad, op_valid, cmd_fill, cmd_xor, cmd_err;
  logic dwr, drd, adv, cur_wr;
  logic [7:0] status_val;

`ifdef GPU_XOR_EN
  logic [7:0] xd;
  logic       xd_load;
`endif

  gpu_rect_walker #(.COORD_W(COORD_W)) u_walker (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_start),
    .step  (w_step),
    .x0    (x0),
    .y0    (y0),
    .x1    (x1),
    .y1    (y1),
    .cx    (cx),
    .cy    (cy),
    .last  (w_last)
  );

  assign busy = (state != S_IDLE);

  // Host access decode: writes other than STATUS are only accepted in IDLE.
  always_comb begin
    idle      = (state == S_IDLE);
    wr_status = ip_wr && (ip_addr == A_STATUS);
    wr_reg    = ip_wr && (ip_addr != A_STATUS);
    wr_ok     = wr_reg && idle;
    wr_drop   = wr_reg && !idle;
    cmd_wr    = wr_ok && (ip_addr == A_CMD);
    rect_bad  = (x1 < x0) || (y1 < y0);
`ifdef GPU_XOR_EN
    op_valid  = (ip_do == CMD_FILL) || (ip_do == CMD_XFILL);
    cmd_xor   = cmd_wr && (ip_do == CMD_XFILL) && !rect_bad;
`else
    op_valid  = (ip_do == CMD_FILL);
    cmd_xor   = 1'b0;
`endif
    cmd_fill  = cmd_wr && (ip_do == CMD_FILL) && !rect_bad;
    cmd_err   = cmd_wr && (!op_valid || rect_bad);
    dwr       = wr_ok && (ip_addr == A_DATA);
    drd       = ip_rd && (ip_addr == A_DATA);
    adv       = dwr || drd;
    cur_wr    = wr_ok && ((ip_addr == A_X0) || (ip_addr == A_Y0));
  end

  // Engine state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next state and memory port drive; requests are held until granted.
  always_comb begin
    state_nx = state;
    fb_we    = 1'b0;
    fb_re    = 1'b0;
    fb_addr  = '0;
    fb_wdata = '0;
    w_start  = 1'b0;
    w_step   = 1'b0;
    pf_go    = 1'b0;
    pf_load  = 1'b0;
`ifdef GPU_XOR_EN
    xd_load  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (cmd_fill) begin
          w_start  = 1'b1;
          state_nx = S_FILL;
        end else if (cmd_xor) begin
          w_start  = 1'b1;
          state_nx = S_XR;
        end else if (dwr) begin
          state_nx = S_DPORT_WR;
        end else if (!ip_wr && pf_stale) begin
          pf_go    = 1'b1;
          state_nx = S_PF_RD;
        end
      end
      S_FILL: begin
        fb_we    = 1'b1;
        fb_addr  = {cy, cx};
        fb_wdata = color;
        if (fb_ready) begin
          if (w_last) begin
            pf_go    = 1'b1;
            state_nx = S_PF_RD;
          end else begin
            w_step = 1'b1;
          end
        end
      end
      S_DPORT_WR: begin
        fb_we    = 1'b1;
        fb_addr  = dp_addr;
        fb_wdata = dp_data;
        if (fb_ready) begin
          pf_go    = 1'b1;
          state_nx = S_PF_RD;
        end
      end
      S_PF_RD: begin
        fb_re   = 1'b1;
        fb_addr = pf_addr;
        if (fb_ready) state_nx = S_PF_WAIT;
      end
      S_PF_WAIT: begin
        pf_load  = 1'b1;
        state_nx = S_IDLE;
      end
`ifdef GPU_XOR_EN
      S_XR: begin
        fb_re   = 1'b1;
        fb_addr = {cy, cx};
        if (fb_ready) state_nx = S_XW;
      end
      S_XW: begin
        xd_load  = 1'b1;
        state_nx = S_XWR;
      end
      S_XWR: begin
        fb_we    = 1'b1;
        fb_addr  = {cy, cx};
        fb_wdata = xd;
        if (fb_ready) begin
          if (w_last) begin
            pf_go    = 1'b1;
            state_nx = S_PF_RD;
          end else begin
            w_step   = 1'b1;
            state_nx = S_XR;
          end
        end
      end
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  // Host registers, cursor auto-advance, sticky error and prefetch staleness.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0       <= '0;
      y0       <= '0;
      x1       <= '0;
      y1       <= '0;
      color    <= '0;
      err      <= 1'b0;
      pf_stale <= 1'b1;
    end else begin
      if (wr_ok) begin
        case (ip_addr)
          A_X0:    x0    <= ip_do[COORD_W-1:0];
          A_Y0:    y0    <= ip_do[COORD_W-1:0];
          A_X1:    x1    <= ip_do[COORD_W-1:0];
          A_Y1:    y1    <= ip_do[COORD_W-1:0];
          A_COLOR: color <= ip_do;
          default: ;
        endcase
      end
      if (adv) begin
        x0 <= x0 + 1'b1;
        if (x0 == '1) y0 <= y0 + 1'b1;
      end
      if (wr_status)               err <= 1'b0;
      else if (wr_drop || cmd_err) err <= 1'b1;
      // A cursor move during an in-flight prefetch wins, forcing a refetch.
      if (adv || cur_wr) pf_stale <= 1'b1;
      else if (pf_go)    pf_stale <= 1'b0;
    end
  end

  // Datapath latches: prefetch address/data, data-port write, XOR operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pf      <= '0;
      pf_addr <= '0;
      dp_addr <= '0;
      dp_data <= '0;
`ifdef GPU_XOR_EN
      xd      <= '0;
`endif
    end else begin
      if (pf_go)   pf_addr <= {y0, x0};
      if (pf_load) pf      <= fb_rdata;
      if (dwr) begin
        dp_addr <= {y0, x0};
        dp_data <= ip_do;
      end
`ifdef GPU_XOR_EN
      if (xd_load) xd <= fb_rdata ^ color;
`endif
    end
  end

  // STATUS word assembly.
  always_comb begin
    status_val          = '0;
    status_val[ST_BUSY] = busy;
    status_val[ST_ERR]  = err;
  end

  // Registered read data, held until the next read strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ip_di <= '0;
    end else if (ip_rd) begin
      case (ip_addr)
        A_X0:     ip_di <= 8'(x0);
        A_Y0:     ip_di <= 8'(y0);
        A_X1:     ip_di <= 8'(x1);
        A_Y1:     ip_di <= 8'(y1);
        A_COLOR:  ip_di <= color;
        A_STATUS: ip_di <= status_val;
        A_DATA:   ip_di <= pf;
        default:  ip_di <= 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_regs.sv
// tb_gpu_regs: directed bench for gpu_regs with a framebuffer model and an
// expected-write queue built from rectangle geometry.
module tb_gpu_regs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  ip_addr = 8'h00;
  logic [7:0]  ip_do = 8'h00;
  logic        ip_wr = 1'b0;
  logic        ip_rd = 1'b0;
  logic [7:0]  ip_di;
  logic [15:0] fb_addr;
  logic [7:0]  fb_wdata;
  logic        fb_we, fb_re;
  logic        fb_ready;
  logic [7:0]  fb_rdata = 8'h00;
  logic        busy;

  logic [7:0]  mem [0:65535];
  logic        pl_en = 1'b0;
  logic [15:0] pl_addr = 16'h0;
  logic [7:0]  pl_data = 8'h0;

  int          total = 0;
  int          bad = 0;
  int          wr_cnt = 0;
  bit          toggle = 1'b0;
  bit          ignore_wr = 1'b0;
  logic [23:0] exp_q[$];
  logic [7:0]  rv;

  always #5 clk = ~clk;

  gpu_regs #(.COORD_W(8), .FB_AW(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ip_addr  (ip_addr),
    .ip_do    (ip_do),
    .ip_wr    (ip_wr),
    .ip_rd    (ip_rd),
    .ip_di    (ip_di),
    .fb_addr  (fb_addr),
    .fb_wdata (fb_wdata),
    .fb_we    (fb_we),
    .fb_re    (fb_re),
    .fb_ready (fb_ready),
    .fb_rdata (fb_rdata),
    .busy     (busy)
  );

  // Framebuffer: writes and reads complete on granted cycles, read data one cycle later.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (fb_ready && fb_we) mem[fb_addr] <= fb_wdata;
    fb_rdata <= (fb_ready && fb_re) ? mem[fb_addr] : 8'h00;
  end

  // Grant generator: always ready, or alternating when toggle is set.
  initial begin
    fb_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      fb_ready = toggle ? ~fb_ready : 1'b1;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push_rect(input int xa, input int ya, input int xb, input int yb, input logic [7:0] c);
    for (int y = ya; y <= yb; y++)
      for (int x = xa; x <= xb; x++)
        exp_q.push_back({y[7:0], x[7:0], c});
  endtask

  // Memory-port checker: exclusivity, stall stability, write order and content.
  task automatic monitor();
    bit pend = 1'b0;
    logic [15:0] pa = '0;
    logic [7:0]  pd = '0;
    logic        pw = 1'b0, pr = 1'b0;
    logic [23:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        if (fb_we || fb_re) chk("we_re_exclusive", {31'b0, fb_we & fb_re}, 32'd0);
        if (pend) chk("stall_hold", {6'b0, fb_we, fb_re, fb_wdata, fb_addr}, {6'b0, pw, pr, pd, pa});
        if (fb_we && fb_ready && !ignore_wr) begin
          wr_cnt++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got addr=0x%0h data=0x%0h required no write", fb_addr, fb_wdata);
          end else begin
            e = exp_q.pop_front();
            chk("fb_write", {8'h0, fb_addr, fb_wdata}, {8'h0, e});
          end
        end
        pend = (fb_we || fb_re) && !fb_ready;
        pa = fb_addr; pd = fb_wdata; pw = fb_we; pr = fb_re;
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    repeat (2) @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", {31'b0, busy}, 32'd0);
  endtask

  task automatic wr_nw(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    ip_addr = a; ip_do = d; ip_wr = 1'b1;
    @(negedge clk);
    ip_wr = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    wr_nw(a, d);
    wait_idle(500);
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    ip_addr = a; ip_rd = 1'b1;
    @(negedge clk);
    ip_rd = 1'b0;
    d = ip_di;
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic main_seq();
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ip_di", {24'h0, ip_di}, 32'h0);
    chk("rst_fb_we", {31'h0, fb_we}, 32'h0);
    chk("rst_fb_re", {31'h0, fb_re}, 32'h0);
    chk("rst_fb_addr", {16'h0, fb_addr}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_idle(50);
    rd(8'h06, rv); chk("rst_status", {24'h0, rv}, 32'h00);

    // 3x2 fill, always granted
    wr(8'h00, 8'h02); wr(8'h01, 8'h03); wr(8'h02, 8'h04); wr(8'h03, 8'h04); wr(8'h04, 8'hAA);
    push_rect(2, 3, 4, 4, 8'hAA);
    wr_cnt = 0;
    wr(8'h05, 8'h01);
    chk("fill_queue_empty", exp_q.size(), 32'd0);
    chk("fill_write_count", wr_cnt, 32'd6);
    rd(8'h06, rv); chk("fill_status", {24'h0, rv}, 32'h00);
    rd(8'h02, rv); chk("x1_readback", {24'h0, rv}, 32'h04);

    // Same fill with alternating grant
    toggle = 1'b1;
    push_rect(2, 3, 4, 4, 8'hAA);
    wr_cnt = 0;
    wr(8'h05, 8'h01);
    toggle = 1'b0;
    chk("stall_fill_queue_empty", exp_q.size(), 32'd0);
    chk("stall_fill_write_count", wr_cnt, 32'd6);

    // Inverted rectangle rejected
    wr(8'h00, 8'h05);
    wr(8'h05, 8'h01);
    rd(8'h06, rv); chk("bad_rect_status", {24'h0, rv}, 32'h02);
    wr(8'h06, 8'h00);
    rd(8'h06, rv); chk("err_cleared", {24'h0, rv}, 32'h00);

    // Write while busy is dropped and flags err
    wr(8'h00, 8'h00); wr(8'h01, 8'h00); wr(8'h02, 8'h0F); wr(8'h03, 8'h00); wr(8'h04, 8'h22);
    push_rect(0, 0, 15, 0, 8'h22);
    wr_nw(8'h05, 8'h01);
    wr_nw(8'h04, 8'h99);
    wait_idle(500);
    chk("busy_fill_queue_empty", exp_q.size(), 32'd0);
    rd(8'h04, rv); chk("busy_write_dropped", {24'h0, rv}, 32'h22);
    rd(8'h06, rv); chk("busy_write_err", {24'h0, rv}, 32'h02);
    wr(8'h06, 8'h00);

    // DATA write goes to cursor and advances it
    wr(8'h00, 8'h20); wr(8'h01, 8'h05);
    exp_q.push_back({16'h0520, 8'h3C});
    wr(8'h07, 8'h3C);
    chk("dport_queue_empty", exp_q.size(), 32'd0);
    rd(8'h00, rv); chk("dport_cursor_x", {24'h0, rv}, 32'h21);

    // DATA reads through prefetch, cursor wraps X into Y
    preload(16'h10FF, 8'h5A);
    preload(16'h1100, 8'h77);
    wr(8'h00, 8'hFF); wr(8'h01, 8'h10);
    rd(8'h07, rv); chk("data_read_0", {24'h0, rv}, 32'h5A);
    wait_idle(50);
    rd(8'h00, rv); chk("wrap_x0", {24'h0, rv}, 32'h00);
    rd(8'h01, rv); chk("wrap_y0", {24'h0, rv}, 32'h11);
    rd(8'h07, rv); chk("data_read_1", {24'h0, rv}, 32'h77);
    wait_idle(50);

    // Single pixel fill, then XOR-FILL over it
    wr(8'h00, 8'h07); wr(8'h01, 8'h07); wr(8'h02, 8'h07); wr(8'h03, 8'h07); wr(8'h04, 8'h0F);
    exp_q.push_back({16'h0707, 8'h0F});
    wr_cnt = 0;
    wr(8'h05, 8'h01);
    chk("pixel_write_count", wr_cnt, 32'd1);
    wr(8'h04, 8'hFF);
`ifdef GPU_XOR_EN
    exp_q.push_back({16'h0707, 8'hF0});
    wr(8'h05, 8'h03);
    chk("xor_queue_empty", exp_q.size(), 32'd0);
    rd(8'h06, rv); chk("xor_status", {24'h0, rv}, 32'h00);
`else
    wr_cnt = 0;
    wr(8'h05, 8'h03);
    chk("xor_no_write", wr_cnt, 32'd0);
    rd(8'h06, rv); chk("xor_invalid_status", {24'h0, rv}, 32'h02);
    wr(8'h06, 8'h00);
`endif

    // Reset during a fill
    wr(8'h00, 8'h00); wr(8'h01, 8'h00); wr(8'h02, 8'h09); wr(8'h03, 8'h09); wr(8'h04, 8'h11);
    ignore_wr = 1'b1;
    wr_nw(8'h05, 8'h01);
    repeat (4) @(negedge clk);
    chk("midfill_busy", {31'h0, busy}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_fb_we", {31'h0, fb_we}, 32'h0);
    chk("async_rst_busy", {31'h0, busy}, 32'h0);
    ignore_wr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_idle(50);
    for (int a = 0; a < 7; a++) begin
      if (a != 5) begin
        rd(a[7:0], rv);
        chk("post_rst_reg", {16'h0, a[7:0], rv}, {16'h0, a[7:0], 8'h00});
      end
    end
    chk("final_queue_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    fork
      monitor();
      main_seq();
    join_any
    disable fork;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
